clk_period_meter: RTL and testbench
===================================

# clk_period_meter

Measures the period and high time of the divided clock produced by the team's programmable clock divider. The divider output is sampled as an asynchronous data signal in the `clk` domain. A capture is triggered by a start pulse and averages over 2^AVG_LOG2 periods, then presents one result with a valid pulse. It sits directly downstream of the divider and lets benches and on-chip status logic confirm the divide ratio and duty cycle.

## Interface
- CNT_W, 16: width of per-period cycle counter; also sets timeout limit 2^CNT_W−1.
- AVG_LOG2, 2: log2 of number of periods averaged (0 = single period).
- SYNC_STAGES, 2: flops in input synchronizer, minimum 2.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- meas_in  in  1  divided clock under measurement; asynchronous to `clk`.
- start  in  1  single-cycle request to begin a capture.
- busy  out  1  high from cycle after accepted start until result or timeout.
- period_out  out  CNT_W  averaged period in `clk` cycles.
- high_out  out  CNT_W  averaged high time in `clk` cycles.
- valid  out  1  one-cycle pulse; `period_out`/`high_out` updated same cycle.
- timeout  out  1  sticky error; set on counter saturation, cleared by next accepted start.

## Operation
- meas_in passes through SYNC_STAGES flops, then one edge-detect flop. This yields `rise` and `fall` pulses.
- States: IDLE, ARM, MEASURE.
  - IDLE: start=1 → ARM, busy←1, timeout←0, accumulators←0, cnt←0. start while busy is ignored.
  - ARM: waits for `rise`. Edges present in the start cycle itself are not used. On `rise` → MEASURE, cnt←1, nper←0.
  - MEASURE:
    - cnt increments every cycle.
    - On `fall`: hsample←cnt.
    - On `rise`: acc_p += cnt, acc_h += hsample, nper++, cnt←1.
    - When nper reaches 2^AVG_LOG2 → IDLE. period_out←acc_p>>AVG_LOG2, high_out←acc_h>>AVG_LOG2 (truncating), valid=1, busy←0.
- Accumulators are CNT_W+AVG_LOG2 bits wide, so the sum cannot overflow.
- Timeout: cnt reaching 2^CNT_W−1 in ARM or MEASURE → IDLE, timeout←1, busy←0, valid stays 0, outputs keep their previous values. A stuck-high or stuck-low input therefore always terminates.
- If no `fall` occurs within a period (glitch-free input guaranteed by the divider), hsample keeps its last value.

## Timing
- Reset values: busy=0, valid=0, timeout=0, period_out=0, high_out=0, state=IDLE, sync chain=0.
- An edge on meas_in produces `rise`/`fall` SYNC_STAGES+1 cycles later. Rise and fall are delayed equally, so measured widths are exact for a synchronous source.
- Period = number of `clk` rising edges between consecutive `rise` pulses. High = cycles from `rise` to `fall`.
- valid asserts in the cycle after the final `rise` is registered. busy falls in that same cycle. A new start is accepted in that cycle.
- Total latency from start ≈ SYNC_STAGES+1 + wait-to-first-edge + 2^AVG_LOG2 × period + 1 cycles.
- Simultaneous `rise` and counter saturation: the rise wins and the period is recorded.
- rst asserted mid-capture: everything returns to reset values immediately, and no valid is emitted.

## Structure
- Shared package/include `clk_meas_pkg` holds:
  - state encoding localparams ST_IDLE/ST_ARM/ST_MEASURE;
  - default CNT_W/AVG_LOG2/SYNC_STAGES;
  - the timeout-limit expression.
- One sub-module, `sync_edge_det`: the SYNC_STAGES synchronizer plus edge detector, with outputs `rise` and `fall`. It is reused by other async-input blocks.
- Top contains the FSM, counter, accumulators and output registers. Target is 150–250 lines of RTL.

## Test plan
- Divider model with 10 ns clk, period 9 cycles, high 4; AVG_LOG2=2, start → one valid, period_out=9, high_out=4, timeout=0, busy low afterwards.
- Period 18 cycles, high 9; AVG_LOG2=0 → period_out=18, high_out=9 after a single period.
- Periods 9,9,10,10 with high 4,4,5,5; AVG_LOG2=2 → period_out=9 (38>>2), high_out=4 (18>>2).
- meas_in held low, CNT_W=8, start → timeout=1 exactly 255 cycles after ARM entry. No valid pulse, period_out unchanged. A second start clears timeout.
- rst pulsed during MEASURE → all outputs 0 next cycle, no valid. A start issued mid-capture is ignored, and the result matches a clean run.
- Start asserted in the same cycle as a `rise` → that edge is not used. Measurement begins on the following rise and the result still equals the programmed period.

Source files
------------

// File: rtl/clk_meas_pkg.sv
// rtl/clk_meas_pkg.sv - shared states, defaults and limits for the clock period meter
package clk_meas_pkg;

  localparam int DEF_CNT_W       = 16;
  localparam int DEF_AVG_LOG2    = 2;
  localparam int DEF_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2
  } meas_state_t;

  // Counter value at which a capture is abandoned (all ones for the counter width)
  function automatic int timeout_limit(input int cnt_w);
    return (1 << cnt_w) - 1;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - multi-flop synchronizer followed by a rise/fall edge detector
module sync_edge_det
  import clk_meas_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES  // must be at least 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Shift the async input through the synchronizer, then keep one delayed copy for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/clk_period_meter.sv
// rtl/clk_period_meter.sv - averaged period and high-time measurement of a divided clock
module clk_period_meter
  import clk_meas_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int AVG_LOG2    = DEF_AVG_LOG2,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             meas_in,
  input  logic             start,
  output logic             busy,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             valid,
  output logic             timeout
);

  localparam int ACC_W  = CNT_W + AVG_LOG2;
  localparam int NPER_W = AVG_LOG2 + 1;

  // Last period index of a capture, and the count value whose increment would saturate
  localparam logic [NPER_W-1:0] NPER_LAST = NPER_W'((1 << AVG_LOG2) - 1);
  localparam logic [CNT_W-1:0]  CNT_SAT   = CNT_W'(timeout_limit(CNT_W) - 1);

  logic rise;
  logic fall;

  meas_state_t       state_q,   state_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;
  logic [NPER_W-1:0] nper_q,    nper_d;
  logic [CNT_W-1:0]  hsample_q, hsample_d;
  logic [ACC_W-1:0]  acc_p_q,   acc_p_d;
  logic [ACC_W-1:0]  acc_h_q,   acc_h_d;
  logic              busy_q,    busy_d;
  logic              valid_q,   valid_d;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  period_q,  period_d;
  logic [CNT_W-1:0]  high_q,    high_d;
  logic [ACC_W-1:0]  acc_p_sum;
  logic [ACC_W-1:0]  acc_h_sum;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (meas_in),
    .rise (rise),
    .fall (fall)
  );

  assign acc_p_sum = acc_p_q + ACC_W'(cnt_q);
  assign acc_h_sum = acc_h_q + ACC_W'(hsample_q);

  // Next-state and datapath decisions; a rise always beats counter saturation
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    nper_d    = nper_q;
    hsample_d = hsample_q;
    acc_p_d   = acc_p_q;
    acc_h_d   = acc_h_q;
    busy_d    = busy_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;
    period_d  = period_q;
    high_d    = high_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_ARM;
          busy_d    = 1'b1;
          timeout_d = 1'b0;
          acc_p_d   = '0;
          acc_h_d   = '0;
          cnt_d     = '0;
        end
      end

      ST_ARM: begin
        cnt_d = cnt_q + 1'b1;
        if (rise) begin
          state_d = ST_MEASURE;
          cnt_d   = CNT_W'(1);
          nper_d  = '0;
        end else if (cnt_q == CNT_SAT) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
          busy_d    = 1'b0;
        end
      end

      ST_MEASURE: begin
        cnt_d = cnt_q + 1'b1;
        if (fall) begin
          hsample_d = cnt_q;
        end
        if (rise) begin
          acc_p_d = acc_p_sum;
          acc_h_d = acc_h_sum;
          nper_d  = nper_q + 1'b1;
          cnt_d   = CNT_W'(1);
          if (nper_q == NPER_LAST) begin
            state_d  = ST_IDLE;
            period_d = CNT_W'(acc_p_sum >> AVG_LOG2);
            high_d   = CNT_W'(acc_h_sum >> AVG_LOG2);
            valid_d  = 1'b1;
            busy_d   = 1'b0;
          end
        end else if (cnt_q == CNT_SAT) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
          busy_d    = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, counters, accumulators and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      nper_q    <= '0;
      hsample_q <= '0;
      acc_p_q   <= '0;
      acc_h_q   <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      period_q  <= '0;
      high_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      nper_q    <= nper_d;
      hsample_q <= hsample_d;
      acc_p_q   <= acc_p_d;
      acc_h_q   <= acc_h_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      period_q  <= period_d;
      high_q    <= high_d;
    end
  end

  assign busy       = busy_q;
  assign valid      = valid_q;
  assign timeout    = timeout_q;
  assign period_out = period_q;
  assign high_out   = high_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// tb/tb_clk_period_meter.sv - scoreboard bench for clk_period_meter
module tb_clk_period_meter;

  typedef struct {
    bit is_to;
    int per;
    int hi;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       meas_in;
  logic       start_a;
  logic       start_b;
  logic       busy_a, valid_a, timeout_a;
  logic       busy_b, valid_b, timeout_b;
  logic [7:0] period_a, high_a, period_b, high_b;

  int   errors = 0;
  int   checks = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  int   pat_p[4];
  int   pat_h[4];
  int   pat_len = 1;
  bit   gen_en  = 1'b0;

  always #5 clk = ~clk;

  clk_period_meter #(.CNT_W(8), .AVG_LOG2(2), .SYNC_STAGES(2)) u_avg4 (
    .clk        (clk),
    .rst        (rst),
    .meas_in    (meas_in),
    .start      (start_a),
    .busy       (busy_a),
    .period_out (period_a),
    .high_out   (high_a),
    .valid      (valid_a),
    .timeout    (timeout_a)
  );

  clk_period_meter #(.CNT_W(8), .AVG_LOG2(0), .SYNC_STAGES(2)) u_avg1 (
    .clk        (clk),
    .rst        (rst),
    .meas_in    (meas_in),
    .start      (start_b),
    .busy       (busy_b),
    .period_out (period_b),
    .high_out   (high_b),
    .valid      (valid_b),
    .timeout    (timeout_b)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Divider model: pattern of (period, high) pairs, edges launched 1 ns after posedge
  initial begin
    meas_in = 1'b0;
    @(posedge clk);
    #1;
    forever begin
      if (!gen_en) begin
        meas_in = 1'b0;
        @(posedge clk);
        #1;
      end else begin
        for (int i = 0; i < pat_len; i++) begin
          meas_in = 1'b1;
          repeat (pat_h[i]) @(posedge clk);
          #1 meas_in = 1'b0;
          repeat (pat_p[i] - pat_h[i]) @(posedge clk);
          #1;
        end
      end
    end
  end

  task automatic on_output(input bit which, input bit is_to, input int per, input int hi, input int busy);
    exp_t  e;
    string tag;
    tag = which ? "b" : "a";
    if ((which ? q_b.size() : q_a.size()) == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_unexpected_output: got timeout=%0d period=%0d high=%0d, required no output",
               tag, is_to, per, hi);
      return;
    end
    e = which ? q_b.pop_front() : q_a.pop_front();
    chk({tag, "_kind_timeout"}, int'(is_to), int'(e.is_to));
    chk({tag, "_period"}, per, e.per);
    chk({tag, "_high"}, hi, e.hi);
    chk({tag, "_busy_at_end"}, busy, 0);
  endtask

  // Monitor: every valid pulse or new timeout is matched against the scoreboard
  initial begin
    bit to_a_prev;
    bit to_b_prev;
    to_a_prev = 1'b0;
    to_b_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        if (valid_a) on_output(1'b0, 1'b0, int'(period_a), int'(high_a), int'(busy_a));
        if (timeout_a && !to_a_prev) on_output(1'b0, 1'b1, int'(period_a), int'(high_a), int'(busy_a));
        if (valid_b) on_output(1'b1, 1'b0, int'(period_b), int'(high_b), int'(busy_b));
        if (timeout_b && !to_b_prev) on_output(1'b1, 1'b1, int'(period_b), int'(high_b), int'(busy_b));
      end
      to_a_prev = timeout_a;
      to_b_prev = timeout_b;
    end
  end

  task automatic pulse_start(input bit which);
    @(posedge clk);
    #1;
    if (which) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic drain(input bit which, input int limit);
    int n;
    n = 0;
    while ((which ? q_b.size() : q_a.size()) != 0 && n < limit) begin
      @(posedge clk);
      n++;
    end
    chk(which ? "b_pending_results" : "a_pending_results", which ? q_b.size() : q_a.size(), 0);
    if (which) q_b.delete(); else q_a.delete();
  endtask

  task automatic set_pat(input int p0, input int h0, input int p1, input int h1,
                         input int p2, input int h2, input int p3, input int h3, input int len);
    gen_en = 1'b0;
    repeat (30) @(posedge clk);
    pat_p   = '{p0, p1, p2, p3};
    pat_h   = '{h0, h1, h2, h3};
    pat_len = len;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_busy_a"}, int'(busy_a), 0);
    chk({tag, "_valid_a"}, int'(valid_a), 0);
    chk({tag, "_timeout_a"}, int'(timeout_a), 0);
    chk({tag, "_period_a"}, int'(period_a), 0);
    chk({tag, "_high_a"}, int'(high_a), 0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  n;
    bit  prev;
    rst     = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    pat_p   = '{9, 9, 9, 9};
    pat_h   = '{4, 4, 4, 4};

    // Reset values on both instances
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_outputs_zero("reset");
    chk("reset_busy_b", int'(busy_b), 0);
    chk("reset_valid_b", int'(valid_b), 0);
    chk("reset_timeout_b", int'(timeout_b), 0);
    chk("reset_period_b", int'(period_b), 0);
    chk("reset_high_b", int'(high_b), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Steady 9/4 divider averaged over four periods
    set_pat(9, 4, 9, 4, 9, 4, 9, 4, 1);
    q_a.push_back('{1'b0, 9, 4});
    pulse_start(1'b0);
    chk("a_busy_after_start", int'(busy_a), 1);
    gen_en = 1'b1;
    drain(1'b0, 200);
    repeat (2) @(posedge clk);
    #1 chk("a_busy_idle", int'(busy_a), 0);

    // 18/9 divider, single period
    set_pat(18, 9, 18, 9, 18, 9, 18, 9, 1);
    q_b.push_back('{1'b0, 18, 9});
    pulse_start(1'b1);
    gen_en = 1'b1;
    drain(1'b1, 200);

    // Uneven periods: 38>>2 = 9, 18>>2 = 4
    set_pat(9, 4, 9, 4, 10, 5, 10, 5, 4);
    q_a.push_back('{1'b0, 9, 4});
    pulse_start(1'b0);
    gen_en = 1'b1;
    drain(1'b0, 200);

    // Input stuck low: timeout 255 cycles after ARM entry, previous result held
    set_pat(9, 4, 9, 4, 9, 4, 9, 4, 1);
    q_a.push_back('{1'b1, 9, 4});
    @(posedge clk);
    #1 start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
    chk("a_busy_in_arm", int'(busy_a), 1);
    n = 0;
    while (!timeout_a && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("a_timeout_latency", n, 255);
    chk("a_busy_after_timeout", int'(busy_a), 0);
    drain(1'b0, 5);
    pulse_start(1'b0);
    chk("a_timeout_cleared", int'(timeout_a), 0);
    chk("a_busy_restart", int'(busy_a), 1);
    q_a.push_back('{1'b0, 9, 4});
    gen_en = 1'b1;
    drain(1'b0, 200);

    // Reset in the middle of a capture: no result, all outputs cleared
    pulse_start(1'b0);
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk_outputs_zero("midrst");
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (60) @(posedge clk);

    // Clean capture with a redundant start issued while busy
    q_a.push_back('{1'b0, 9, 4});
    pulse_start(1'b0);
    repeat (15) @(posedge clk);
    pulse_start(1'b0);
    drain(1'b0, 200);
    repeat (5) @(posedge clk);

    // Start coincident with a registered rise: that edge is skipped, valid 45 cycles later
    n = 0;
    @(posedge clk);
    #2 prev = meas_in;
    while (!(meas_in && !prev) && n < 40) begin
      prev = meas_in;
      @(posedge clk);
      #2;
      n++;
    end
    chk("sync_edge_found", int'(n < 40), 1);
    @(posedge clk);
    @(posedge clk);
    #1 start_a = 1'b1;
    q_a.push_back('{1'b0, 9, 4});
    @(posedge clk);
    #1 start_a = 1'b0;
    n = 0;
    while (!valid_a && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("a_start_on_rise_latency", n, 45);
    drain(1'b0, 5);

    gen_en = 1'b0;
    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
